cdc_conv_sequencer: RTL and testbench

Synchronous scan controller for the capacitance-to-digital converter core. It steps the sensor mux through an enabled set of channels and, for each channel, holds the converter in reset and then releases it. It counts the converter's edge pulses until the conversion-finished flag appears or a timeout expires. Each per-channel result is delivered over a valid/ready handshake. It sits between the system bus/register file and the asynchronous converter clock generator.

---
 rtl/cdc_conv_sequencer_pkg.sv | 14 +
 rtl/cdc_defs.vh | 15 +
 rtl/cdc_sync2.sv | 21 ++
 rtl/cdc_conv_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_cdc_conv_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_conv_sequencer_pkg.sv
// Types shared by the converter scan controller.
`include "cdc_defs.vh"

package cdc_conv_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = `CDC_ST_IDLE,
    ST_SETTLE   = `CDC_ST_SETTLE,
    ST_CONV_RST = `CDC_ST_CONV_RST,
    ST_MEASURE  = `CDC_ST_MEASURE,
    ST_OUTPUT   = `CDC_ST_OUTPUT
  } state_t;

endpackage

// File: rtl/cdc_defs.vh
// Shared definitions for the converter scan controller: state encodings and
// default timing values.
`ifndef CDC_DEFS_VH
`define CDC_DEFS_VH

`define CDC_ST_IDLE         3'd0
`define CDC_ST_SETTLE       3'd1
`define CDC_ST_CONV_RST     3'd2
`define CDC_ST_MEASURE      3'd3
`define CDC_ST_OUTPUT       3'd4

`define CDC_TIMEOUT_CYC_DEF 4095
`define CDC_SETTLE_CYC_DEF  8

`endif

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous converter signal.
module cdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_conv_sequencer.sv
// Scan controller for the capacitance-to-digital converter core.
// Optional per-channel averaging is enabled with the CDC_AVERAGE_EN macro.
`include "cdc_defs.vh"

module cdc_conv_sequencer
  import cdc_conv_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SETTLE_CYC  = `CDC_SETTLE_CYC_DEF,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = `CDC_TIMEOUT_CYC_DEF
`ifdef CDC_AVERAGE_EN
  , parameter int unsigned AVG_LOG2  = 2
`endif
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [NUM_CH-1:0] Ch_Enable,
  input  logic              Next_Edge,
  input  logic              Conv_Finish,
  output logic              Conv_Reset,
  output logic [CH_W-1:0]   Ch_Sel,
  output logic              Busy,
  output logic              Res_Valid,
  input  logic              Res_Ready,
  output logic [CNT_W-1:0]  Res_Data,
  output logic [CH_W-1:0]   Res_Ch,
  output logic              Res_Timeout
);

  localparam int unsigned TMR_MAX = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
`ifdef CDC_AVERAGE_EN
  localparam int unsigned ACC_W   = CNT_W + AVG_LOG2;
`endif

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TO_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [CH_W-1:0]    ch_sel_q, ch_sel_d;
  logic [CNT_W-1:0]   res_data_q, res_data_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic               res_to_q, res_to_d;
  logic               conv_reset_q, busy_q, res_valid_q;
  logic               edge_s, fin_s, edge_q, edge_rise;
  logic               timeout;
  logic               first_found, nxt_found;
  logic [CH_W-1:0]    first_ch, nxt_ch;
`ifdef CDC_AVERAGE_EN
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] rep_q, rep_d;
`endif

  cdc_sync2 u_sync_edge (.clk(CLK), .rst(Reset), .d(Next_Edge),   .q(edge_s));
  cdc_sync2 u_sync_fin  (.clk(CLK), .rst(Reset), .d(Conv_Finish), .q(fin_s));

  assign edge_rise = edge_s & ~edge_q;

  // Lowest enabled channel of the incoming mask, and next higher one in the latched mask.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (Ch_Enable[i]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(ch_sel_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cyc_d      = cyc_q;
    edge_cnt_d = edge_cnt_q;
    mask_d     = mask_q;
    ch_sel_d   = ch_sel_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    res_to_d   = res_to_q;
    timeout    = 1'b0;
`ifdef CDC_AVERAGE_EN
    acc_d      = acc_q;
    rep_d      = rep_q;
    acc_sum    = acc_q + ACC_W'(edge_cnt_q);
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start && first_found) begin
          mask_d   = Ch_Enable;
          ch_sel_d = first_ch;
          tmr_d    = '0;
          state_d  = ST_SETTLE;
`ifdef CDC_AVERAGE_EN
          acc_d    = '0;
          rep_d    = '0;
`endif
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
          tmr_d   = '0;
          state_d = ST_CONV_RST;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_CONV_RST: begin
        edge_cnt_d = '0;
        cyc_d      = '0;
        if (tmr_q == TMR_W'(RST_CYC - 1)) begin
          tmr_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        cyc_d   = cyc_q + TO_W'(1);
        timeout = (cyc_d == TO_W'(TIMEOUT_CYC));
        // An edge in the exit cycle is deliberately not counted.
        if (fin_s || timeout) begin
`ifdef CDC_AVERAGE_EN
          if (!fin_s || (rep_q == '1)) begin
            res_data_d = CNT_W'(acc_sum >> AVG_LOG2);
            res_ch_d   = ch_sel_q;
            res_to_d   = ~fin_s;
            state_d    = ST_OUTPUT;
          end else begin
            acc_d   = acc_sum;
            rep_d   = rep_q + AVG_LOG2'(1);
            tmr_d   = '0;
            state_d = ST_CONV_RST;
          end
`else
          res_data_d = edge_cnt_q;
          res_ch_d   = ch_sel_q;
          res_to_d   = ~fin_s;
          state_d    = ST_OUTPUT;
`endif
        end else if (edge_rise && (edge_cnt_q != '1)) begin
          edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (Res_Ready) begin
          if (nxt_found) begin
            ch_sel_d = nxt_ch;
            tmr_d    = '0;
            state_d  = ST_SETTLE;
`ifdef CDC_AVERAGE_EN
            acc_d    = '0;
            rep_d    = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      cyc_q        <= '0;
      edge_cnt_q   <= '0;
      mask_q       <= '0;
      ch_sel_q     <= '0;
      res_data_q   <= '0;
      res_ch_q     <= '0;
      res_to_q     <= 1'b0;
      conv_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      edge_q       <= 1'b0;
`ifdef CDC_AVERAGE_EN
      acc_q        <= '0;
      rep_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cyc_q        <= cyc_d;
      edge_cnt_q   <= edge_cnt_d;
      mask_q       <= mask_d;
      ch_sel_q     <= ch_sel_d;
      res_data_q   <= res_data_d;
      res_ch_q     <= res_ch_d;
      res_to_q     <= res_to_d;
      conv_reset_q <= (state_d != ST_MEASURE);
      busy_q       <= (state_d != ST_IDLE);
      res_valid_q  <= (state_d == ST_OUTPUT);
      edge_q       <= edge_s;
`ifdef CDC_AVERAGE_EN
      acc_q        <= acc_d;
      rep_q        <= rep_d;
`endif
    end
  end

  assign Conv_Reset  = conv_reset_q;
  assign Ch_Sel      = ch_sel_q;
  assign Busy        = busy_q;
  assign Res_Valid   = res_valid_q;
  assign Res_Data    = res_data_q;
  assign Res_Ch      = res_ch_q;
  assign Res_Timeout = res_to_q;

endmodule

// File: tb/tb_cdc_conv_sequencer.sv
// Directed bench for cdc_conv_sequencer: main DUT plus a narrow-counter
// instance for saturation.
module tb_cdc_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic       nedge = 1'b0;
  logic       fin = 1'b0;
  logic       ready = 1'b1;
  logic       conv_rst, busy, valid, res_to;
  logic [1:0] ch_sel, res_ch;
  logic [15:0] res_data;

  logic       s_start = 1'b0;
  logic [3:0] s_ch_en = 4'b0000;
  logic       s_edge = 1'b0;
  logic       s_fin = 1'b0;
  logic       s_conv_rst, s_busy, s_valid, s_res_to;
  logic [1:0] s_ch_sel, s_res_ch;
  logic [3:0] s_res_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cdc_conv_sequencer dut (
    .CLK(clk), .Reset(rst), .Start(start), .Ch_Enable(ch_en),
    .Next_Edge(nedge), .Conv_Finish(fin), .Conv_Reset(conv_rst),
    .Ch_Sel(ch_sel), .Busy(busy), .Res_Valid(valid), .Res_Ready(ready),
    .Res_Data(res_data), .Res_Ch(res_ch), .Res_Timeout(res_to)
  );

  cdc_conv_sequencer #(.CNT_W(4)) dut_sat (
    .CLK(clk), .Reset(rst), .Start(s_start), .Ch_Enable(s_ch_en),
    .Next_Edge(s_edge), .Conv_Finish(s_fin), .Conv_Reset(s_conv_rst),
    .Ch_Sel(s_ch_sel), .Busy(s_busy), .Res_Valid(s_valid), .Res_Ready(1'b1),
    .Res_Data(s_res_data), .Res_Ch(s_res_ch), .Res_Timeout(s_res_to)
  );

  // Bounded wait: 0 Conv_Reset low, 1 Res_Valid high, 2 Conv_Reset high,
  // 3 sat Conv_Reset low, 4 sat Res_Valid high.
  task automatic wait_for(input int which, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < 6000) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = !conv_rst;
        1: hit = valid;
        2: hit = conv_rst;
        3: hit = !s_conv_rst;
        default: hit = s_valid;
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wait_%s: condition not seen after %0d cycles, required within 6000", name, n);
    end
  endtask

  task automatic send_edges(input int n);
    for (int i = 0; i < n; i++) begin
      nedge = 1'b1;
      @(negedge clk);
      nedge = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 7;
    if (conv_rst !== 1'b1) begin bad++; $display("FAIL rst_conv_reset: got %b want 1", conv_rst); end
    if (ch_sel !== 2'd0) begin bad++; $display("FAIL rst_ch_sel: got %0d want 0", ch_sel); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    if (res_data !== 16'd0) begin bad++; $display("FAIL rst_data: got %0d want 0", res_data); end
    if (res_ch !== 2'd0) begin bad++; $display("FAIL rst_res_ch: got %0d want 0", res_ch); end
    if (res_to !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", res_to); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_channel;
    int n;
    ready = 1'b1;
    start = 1'b1;
    ch_en = 4'b0101;
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end
    if (ch_sel !== 2'd0) begin bad++; $display("FAIL start_ch_sel: got %0d want 0", ch_sel); end
    n = 1;
    while (conv_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 13) begin bad++; $display("FAIL start_to_release: got %0d cycles want 13", n); end
    send_edges(37);
    fin = 1'b1;
    wait_for(1, "ch0_valid");
    fin = 1'b0;
    total += 4;
    if (res_ch !== 2'd0) begin bad++; $display("FAIL ch0_res_ch: got %0d want 0", res_ch); end
    if (res_data !== 16'd37) begin bad++; $display("FAIL ch0_data: got %0d want 37", res_data); end
    if (res_to !== 1'b0) begin bad++; $display("FAIL ch0_timeout: got %b want 0", res_to); end
    if (conv_rst !== 1'b1) begin bad++; $display("FAIL ch0_out_conv_reset: got %b want 1", conv_rst); end
    wait_for(0, "ch2_measure");
    total++;
    if (ch_sel !== 2'd2) begin bad++; $display("FAIL ch2_ch_sel: got %0d want 2", ch_sel); end
    send_edges(12);
    fin = 1'b1;
    wait_for(1, "ch2_valid");
    fin = 1'b0;
    total += 3;
    if (res_ch !== 2'd2) begin bad++; $display("FAIL ch2_res_ch: got %0d want 2", res_ch); end
    if (res_data !== 16'd12) begin bad++; $display("FAIL ch2_data: got %0d want 12", res_data); end
    if (res_to !== 1'b0) begin bad++; $display("FAIL ch2_timeout: got %b want 0", res_to); end
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL scan_end_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin bad++; $display("FAIL scan_end_valid: got %b want 0", valid); end
  endtask

  task automatic test_hold;
    ready = 1'b0;
    start = 1'b1;
    ch_en = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, "hold_measure");
    send_edges(5);
    fin = 1'b1;
    wait_for(1, "hold_valid");
    fin = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || res_data !== 16'd5 || res_ch !== 2'd0 || res_to !== 1'b0 ||
          conv_rst !== 1'b1 || ch_sel !== 2'd0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got v=%b d=%0d ch=%0d to=%b crst=%b sel=%0d want v=1 d=5 ch=0 to=0 crst=1 sel=0",
                 i, valid, res_data, res_ch, res_to, conv_rst, ch_sel);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    total += 2;
    if (ch_sel !== 2'd1) begin bad++; $display("FAIL hold_release_sel: got %0d want 1", ch_sel); end
    if (valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b want 0", valid); end
    wait_for(0, "hold_ch1_measure");
    send_edges(3);
    fin = 1'b1;
    wait_for(1, "hold_ch1_valid");
    fin = 1'b0;
    total += 2;
    if (res_ch !== 2'd1) begin bad++; $display("FAIL hold_ch1_res_ch: got %0d want 1", res_ch); end
    if (res_data !== 16'd3) begin bad++; $display("FAIL hold_ch1_data: got %0d want 3", res_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    ready = 1'b1;
    start = 1'b1;
    ch_en = 4'b1000;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, "to_measure");
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (valid) break;
      nedge = (n < 10) && (n % 2 == 1);
    end
    nedge = 1'b0;
    total += 4;
    if (n != 4095) begin bad++; $display("FAIL to_latency: got %0d cycles want 4095", n); end
    if (res_to !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", res_to); end
    if (res_data !== 16'd5) begin bad++; $display("FAIL to_data: got %0d want 5", res_data); end
    if (res_ch !== 2'd3) begin bad++; $display("FAIL to_res_ch: got %0d want 3", res_ch); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL to_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_saturate;
    s_start = 1'b1;
    s_ch_en = 4'b0001;
    @(negedge clk);
    s_start = 1'b0;
    wait_for(3, "sat_measure");
    for (int i = 0; i < 20; i++) begin
      s_edge = 1'b1;
      @(negedge clk);
      s_edge = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    s_fin = 1'b1;
    wait_for(4, "sat_valid");
    s_fin = 1'b0;
    total += 2;
    if (s_res_data !== 4'd15) begin bad++; $display("FAIL sat_data: got %0d want 15", s_res_data); end
    if (s_res_to !== 1'b0) begin bad++; $display("FAIL sat_timeout: got %b want 0", s_res_to); end
    @(negedge clk);
    total++;
    if (s_busy !== 1'b0) begin bad++; $display("FAIL sat_end_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    ch_en = 4'b0100;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, "mid_measure");
    send_edges(3);
    rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (conv_rst !== 1'b1) begin bad++; $display("FAIL mid_conv_reset: got %b want 1", conv_rst); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", valid); end
    if (ch_sel !== 2'd0) begin bad++; $display("FAIL mid_ch_sel: got %0d want 0", ch_sel); end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ch_en = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (busy !== 1'b0 || conv_rst !== 1'b1 || valid !== 1'b0) begin
        bad++;
        $display("FAIL zero_mask_cycle%0d: got busy=%b crst=%b v=%b want 0 1 0", i, busy, conv_rst, valid);
      end
      @(negedge clk);
    end
  endtask

`ifdef CDC_AVERAGE_EN
  task automatic test_average;
    int counts [4];
    counts = '{10, 11, 12, 13};
    ready = 1'b1;
    start = 1'b1;
    ch_en = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wait_for(0, "avg_measure");
      send_edges(counts[r]);
      fin = 1'b1;
      if (r < 3) begin
        wait_for(2, "avg_rearm");
        fin = 1'b0;
      end
    end
    wait_for(1, "avg_valid");
    fin = 1'b0;
    total += 2;
    if (res_data !== 16'd11) begin bad++; $display("FAIL avg_data: got %0d want 11", res_data); end
    if (res_to !== 1'b0) begin bad++; $display("FAIL avg_timeout: got %b want 0", res_to); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
`ifdef CDC_AVERAGE_EN
    test_average;
`else
    test_two_channel;
    test_hold;
    test_timeout;
    test_saturate;
    test_reset_mid;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
